// File: rtl/tlc_pkg.sv
// Shared types for the traffic-light phase scheduler: phase encoding,
// LED patterns, the service-ring index and the round-robin grant helper.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_EW_GREEN  = 3'd2,
    ST_EW_YELLOW = 3'd3,
    ST_PED_WALK  = 3'd4,
    ST_ALL_RED   = 3'd5,
    ST_EMERG     = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    RING_NS  = 2'd0,
    RING_EW  = 2'd1,
    RING_PED = 2'd2
  } ring_t;

  // One-hot {red, yellow, green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int TIMER_W = 8;

  // First pending phase in ring order NS->EW->PED after the last served one;
  // NS when nothing is pending.
  function automatic ring_t next_grant(input ring_t last, input logic ns_p,
                                       input logic ew_p, input logic ped_p);
    ring_t g;
    g = RING_NS;
    case (last)
      RING_NS: begin
        if (ew_p)       g = RING_EW;
        else if (ped_p) g = RING_PED;
        else            g = RING_NS;
      end
      RING_EW: begin
        if (ped_p)      g = RING_PED;
        else if (ns_p)  g = RING_NS;
        else if (ew_p)  g = RING_EW;
        else            g = RING_NS;
      end
      RING_PED: begin
        if (ns_p)       g = RING_NS;
        else if (ew_p)  g = RING_EW;
        else if (ped_p) g = RING_PED;
        else            g = RING_NS;
      end
      default: g = RING_NS;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Cycles-in-phase counter: cleared by load on phase entry, otherwise counts
// up and saturates at all-ones.
module tlc_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               count <= '0;
    else if (load)            count <= '0;
    else if (count != '1)     count <= count + 1'b1;
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Four-way intersection phase scheduler with pedestrian walk, round-robin
// service of pending requests and emergency preemption. Moore outputs.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Pedestrian_req,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       emerg,
  output logic [2:0] NS_LEDS,
  output logic [2:0] EW_LEDS,
  output logic       Pedestrian_allow,
  output logic [2:0] phase
);

  // Thresholds are "last cycle of the interval" values of the timer
  localparam logic [TIMER_W-1:0] MIN_T  = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_T  = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_T  = TIMER_W'(YELLOW - 1);
  localparam logic [TIMER_W-1:0] AR_T   = TIMER_W'(ALL_RED - 1);
  localparam logic [TIMER_W-1:0] WALK_T = TIMER_W'(WALK - 1);

  phase_t               state, state_nx;
  ring_t                last_served, grant;
  logic                 ns_pend, ew_pend, ped_pend, from_emerg;
  logic                 enter;
  logic [TIMER_W-1:0]   t;
  logic [2:0]           ns_leds_nx, ew_leds_nx;
  logic                 allow_nx;

  assign enter = (state_nx != state);
  assign phase = state;

  tlc_phase_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (enter),
    .count (t)
  );

  always_comb begin
    state_nx = state;
    grant    = next_grant(last_served, ns_pend, ew_pend, ped_pend);
    case (state)
      ST_NS_GREEN: begin
        if (emerg)
          state_nx = ST_NS_YELLOW;
        else if ((ew_pend || ped_pend) && ((t >= MIN_T && !ns_car) || t >= MAX_T))
          state_nx = ST_NS_YELLOW;
      end
      ST_EW_GREEN: begin
        if (emerg || (t >= MIN_T && !ew_car) || t >= MAX_T)
          state_nx = ST_EW_YELLOW;
      end
      ST_NS_YELLOW, ST_EW_YELLOW: begin
        if (t == YEL_T) state_nx = ST_ALL_RED;
      end
      ST_PED_WALK: begin
        if (emerg || t == WALK_T) state_nx = ST_ALL_RED;
      end
      ST_ALL_RED: begin
        if (t == AR_T) begin
          if (emerg)           state_nx = ST_EMERG;
          else if (from_emerg) state_nx = ST_NS_GREEN;
          else begin
            case (grant)
              RING_EW:  state_nx = ST_EW_GREEN;
              RING_PED: state_nx = ST_PED_WALK;
              default:  state_nx = ST_NS_GREEN;
            endcase
          end
        end
      end
      ST_EMERG: begin
        if (!emerg) state_nx = ST_ALL_RED;
      end
      default: state_nx = ST_NS_GREEN;
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state register.
  always_comb begin
    ns_leds_nx = RED;
    ew_leds_nx = RED;
    allow_nx   = 1'b0;
    case (state_nx)
      ST_NS_GREEN:  ns_leds_nx = GRN;
      ST_NS_YELLOW: ns_leds_nx = YEL;
      ST_EW_GREEN:  ew_leds_nx = GRN;
      ST_EW_YELLOW: ew_leds_nx = YEL;
      ST_PED_WALK:  allow_nx   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_NS_GREEN;
      last_served      <= RING_NS;
      ns_pend          <= 1'b0;
      ew_pend          <= 1'b0;
      ped_pend         <= 1'b0;
      from_emerg       <= 1'b0;
      NS_LEDS          <= GRN;
      EW_LEDS          <= RED;
      Pedestrian_allow <= 1'b0;
    end else begin
      state            <= state_nx;
      NS_LEDS          <= ns_leds_nx;
      EW_LEDS          <= ew_leds_nx;
      Pedestrian_allow <= allow_nx;
      // Entry clear beats a coincident request
      ns_pend  <= (ns_pend  | ns_car)         & ~(enter && state_nx == ST_NS_GREEN);
      ew_pend  <= (ew_pend  | ew_car)         & ~(enter && state_nx == ST_EW_GREEN);
      ped_pend <= (ped_pend | Pedestrian_req) & ~(enter && state_nx == ST_PED_WALK);
      if (enter) begin
        case (state_nx)
          ST_NS_GREEN: last_served <= RING_NS;
          ST_EW_GREEN: last_served <= RING_EW;
          ST_PED_WALK: last_served <= RING_PED;
          default: ;
        endcase
      end
      // Remember that the current clearance follows an emergency hold
      if (state == ST_EMERG)                   from_emerg <= 1'b1;
      else if (state == ST_ALL_RED && enter)   from_emerg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: expected phase runs {phase, length} are
// queued per scenario and compared as the DUT completes each run.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  localparam int W = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ped_req = 1'b0;
  logic       ns_car = 1'b0;
  logic       ew_car = 1'b0;
  logic       emerg = 1'b0;
  logic [2:0] ns_leds, ew_leds, phase;
  logic       allow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic         mon_fresh = 1'b0;
  logic [2:0]   cur_ph = 3'd0;
  int           cur_len = 0;
  int           allow_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tlc_phase_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .Pedestrian_req   (ped_req),
    .ns_car           (ns_car),
    .ew_car           (ew_car),
    .emerg            (emerg),
    .NS_LEDS          (ns_leds),
    .EW_LEDS          (ew_leds),
    .Pedestrian_allow (allow),
    .phase            (phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_run(input phase_t ph, input int len);
    exp_q.push_back({ph, 8'(len)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ns_leds"}, 32'(ns_leds), 32'(3'b001));
    check({tag, "_ew_leds"}, 32'(ew_leds), 32'(3'b100));
    check({tag, "_allow"},   32'(allow),   32'(1'b0));
    check({tag, "_phase"},   32'(phase),   32'(ST_NS_GREEN));
  endtask

  // Holds reset for two cycles with the given car levels, then releases it
  // just after a rising edge; the following cycle is the first one tracked.
  task automatic do_reset(input logic ns_c, input logic ew_c);
    mon_en  = 1'b0;
    reset   = 1'b0;
    ped_req = 1'b0;
    emerg   = 1'b0;
    ns_car  = ns_c;
    ew_car  = ew_c;
    exp_q.delete();
    allow_cnt = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mon_fresh = 1'b1;
    mon_en    = 1'b1;
  endtask

  task automatic wait_phase(input phase_t ph, input int max_cyc);
    int n;
    n = 0;
    while (phase !== ph && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_phase", 32'(phase), 32'(ph));
  endtask

  // Waits for all queued runs to complete, then confirms the rest phase holds
  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (6) @(negedge clk);
    check("rest_phase", 32'(phase), 32'(ST_NS_GREEN));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic ns_live, ew_live;
    logic [W-1:0] e;
    ns_live = (ns_leds != 3'b100);
    ew_live = (ew_leds != 3'b100);
    check("safety", 32'((ns_live && ew_live) || (allow && (ns_live || ew_live))), 32'd0);
    if (mon_en) begin
      if (allow) allow_cnt++;
      if (mon_fresh) begin
        cur_ph    = phase;
        cur_len   = 1;
        mon_fresh = 1'b0;
      end else if (phase == cur_ph) begin
        cur_len++;
      end else begin
        if (exp_q.size() == 0) begin
          check("extra_run", 32'({cur_ph, 8'(cur_len)}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("run_phase", 32'(cur_ph), 32'(e[10:8]));
          check("run_len", 32'(cur_len), 32'(e[7:0]));
        end
        case (phase)
          ST_NS_GREEN: check("ns_pend_entry",  32'(dut.ns_pend),  32'd0);
          ST_EW_GREEN: check("ew_pend_entry",  32'(dut.ew_pend),  32'd0);
          ST_PED_WALK: check("ped_pend_entry", 32'(dut.ped_pend), 32'd0);
          default: ;
        endcase
        cur_ph  = phase;
        cur_len = 1;
      end
    end
  end

  // ---------------- scenarios ----------------
  initial begin
    // Idle: rests in NS green
    do_reset(1'b0, 1'b0);
    repeat (50) begin
      @(negedge clk);
      check("idle_ns_leds", 32'(ns_leds), 32'(3'b001));
      check("idle_ew_leds", 32'(ew_leds), 32'(3'b100));
    end
    check("idle_phase", 32'(phase), 32'(ST_NS_GREEN));

    // Pedestrian pulse two cycles after release
    do_reset(1'b0, 1'b0);
    push_run(ST_NS_GREEN, 4); push_run(ST_NS_YELLOW, 2); push_run(ST_ALL_RED, 1);
    push_run(ST_PED_WALK, 4); push_run(ST_ALL_RED, 1);
    @(posedge clk); @(posedge clk); #1 ped_req = 1'b1;
    @(posedge clk); #1 ped_req = 1'b0;
    wait_drain(60);
    check("ped_allow_cycles", 32'(allow_cnt), 32'd4);

    // Both sensors held: max-green alternation
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      push_run(ST_NS_GREEN, 10); push_run(ST_NS_YELLOW, 2); push_run(ST_ALL_RED, 1);
      push_run(ST_EW_GREEN, 10); push_run(ST_EW_YELLOW, 2); push_run(ST_ALL_RED, 1);
    end
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 120) begin
        @(negedge clk);
        n++;
      end
      check("alt_drain", 32'(exp_q.size()), 32'd0);
    end

    // EW and PED pending together: EW, then PED, then back to NS
    do_reset(1'b0, 1'b0);
    push_run(ST_NS_GREEN, 4); push_run(ST_NS_YELLOW, 2); push_run(ST_ALL_RED, 1);
    push_run(ST_EW_GREEN, 4); push_run(ST_EW_YELLOW, 2); push_run(ST_ALL_RED, 1);
    push_run(ST_PED_WALK, 4); push_run(ST_ALL_RED, 1);
    @(posedge clk); #1 begin ew_car = 1'b1; ped_req = 1'b1; end
    @(posedge clk); #1 begin ew_car = 1'b0; ped_req = 1'b0; end
    wait_drain(80);
    check("ring_allow_cycles", 32'(allow_cnt), 32'd4);

    // Emergency at t=1 of EW green, held 8 cycles; ped request during EMERG
    do_reset(1'b0, 1'b1);
    push_run(ST_NS_GREEN, 4); push_run(ST_NS_YELLOW, 2); push_run(ST_ALL_RED, 1);
    push_run(ST_EW_GREEN, 2); push_run(ST_EW_YELLOW, 2); push_run(ST_ALL_RED, 1);
    push_run(ST_EMERG, 5);    push_run(ST_ALL_RED, 1);
    push_run(ST_NS_GREEN, 4); push_run(ST_NS_YELLOW, 2); push_run(ST_ALL_RED, 1);
    push_run(ST_PED_WALK, 4); push_run(ST_ALL_RED, 1);
    @(posedge clk); #1 ew_car = 1'b0;
    wait_phase(ST_EW_GREEN, 40);
    @(posedge clk); #1 emerg = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      ped_req = (i == 5);
      if (i == 8) emerg = 1'b0;
    end
    wait_drain(80);
    check("emerg_allow_cycles", 32'(allow_cnt), 32'd4);

    // Asynchronous reset in the middle of a walk
    do_reset(1'b0, 1'b0);
    push_run(ST_NS_GREEN, 4); push_run(ST_NS_YELLOW, 2); push_run(ST_ALL_RED, 1);
    push_run(ST_PED_WALK, 4); push_run(ST_ALL_RED, 1);
    @(posedge clk); @(posedge clk); #1 ped_req = 1'b1;
    @(posedge clk); #1 ped_req = 1'b0;
    wait_phase(ST_PED_WALK, 30);
    @(posedge clk);
    #2;
    check("walk_allow_before_reset", 32'(allow), 32'd1);
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("held_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
